// File: rtl/bash_f_const_rev.sv
// ============================================================================
// Module   : bash_f_const_rev
// Brief    : Backward-stepping bash-f round-constant generator with a
//            valid/ready output stream. Optional forward self-check is
//            enabled by BASH_F_CONST_REV_CHK_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bash_f_const_rev #(
  parameter logic [63:0] C_CONST = 64'hAED8E07F99E12BDC,
  parameter int          CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [63:0]      seed_i,
  input  logic [CNT_W-1:0] steps_i,
  output logic             busy_o,
  output logic [63:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Data order keeps stream byte 0 in bits [63:56]; arithmetic is done on
  // the little-endian integer, so words are byte-swapped around each step.
  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[56-8*i +: 8];
    end
    return r;
  endfunction

  // Bit 7 in data order is LE bit 63, set only when the forward step folded in C.
  function automatic logic [63:0] inv_step(input logic [63:0] y);
    logic        b;
    logic [63:0] t;
    logic [63:0] t_le;
    b    = y[7];
    t    = b ? (y ^ C_CONST) : y;
    t_le = bswap64(t);
    return bswap64({t_le[62:0], b});
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [63:0]      r_word;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_data;
  logic             r_valid;
  logic             r_done;
  logic             w_hs;
  logic             w_last;
  logic [63:0]      w_step_in;
  logic [63:0]      w_step_out;

  assign w_hs       = r_valid & ready_i;
  assign w_last     = (r_cnt == CNT_W'(1));
  // First word comes from the latched seed, later words chain off data_o.
  assign w_step_in  = r_valid ? r_data : r_word;
  assign w_step_out = inv_step(w_step_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = (steps_i == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_hs && w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_word  <= seed_i;
            r_cnt   <= steps_i;
            r_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (!r_valid) begin
            r_data  <= w_step_out;
            r_valid <= 1'b1;
          end else if (w_hs) begin
            r_word <= r_data;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (w_last) begin
              r_valid <= 1'b0;
            end else begin
              r_data <= w_step_out;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = (r_state == S_RUN);
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign done_o  = r_done;

`ifdef BASH_F_CONST_REV_CHK_FWD_EN
  function automatic logic [63:0] fwd_step(input logic [63:0] y);
    logic [63:0] x_le;
    logic [63:0] r_le;
    x_le = bswap64(y);
    r_le = (x_le >> 1) ^ (x_le[0] ? bswap64(C_CONST) : 64'd0);
    return bswap64(r_le);
  endfunction

  logic        r_err;
  logic [63:0] w_fwd;

  // r_word holds the predecessor of data_o (the seed for the first word).
  assign w_fwd = fwd_step(r_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_hs && (w_fwd != r_word)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bash_f_const_rev.sv
// ============================================================================
// Module   : tb_bash_f_const_rev
// Brief    : Directed table-driven bench for bash_f_const_rev.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bash_f_const_rev;

  localparam logic [63:0] C = 64'hAED8E07F99E12BDC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [63:0] seed_i;
  logic [4:0]  steps_i;
  logic        busy_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        done_o;
  logic        err_o;

  bash_f_const_rev dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .seed_i  (seed_i),
    .steps_i (steps_i),
    .busy_o  (busy_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] le(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
    return r;
  endfunction

  // Forward generator step, used to verify the backward chain.
  function automatic logic [63:0] fwd(input logic [63:0] y);
    logic [63:0] x;
    x = le(y);
    return le((x >> 1) ^ (x[0] ? le(C) : 64'd0));
  endfunction

  typedef struct packed {
    logic [63:0]      seed;
    logic [4:0]       steps;
    int               stall_word;
    int               stall_len;
    bit               hold_start;
    logic [2:0][63:0] exp;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic [63:0] seed, input logic [4:0] steps,
                              input int sw, input int sl, input bit hs,
                              input logic [63:0] e0, input logic [63:0] e1,
                              input logic [63:0] e2);
    vec_t v;
    v.seed = seed; v.steps = steps; v.stall_word = sw; v.stall_len = sl;
    v.hold_start = hs; v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    return v;
  endfunction

  task automatic run_stream(input logic [63:0] seed, input logic [4:0] steps,
                            input int stall_word, input int stall_len,
                            input bit hold_start, input bit use_exp,
                            input logic [2:0][63:0] exp, input string tag);
    logic [63:0] prev;
    int k, stalls;
    bit fin;
    @(negedge clk);
    start_i = 1'b1; seed_i = seed; steps_i = steps; ready_i = 1'b1;
    prev = seed; k = 0; stalls = 0; fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (!hold_start) start_i = 1'b0;
      else begin
        seed_i  = 64'h0123456789ABCDEF;
        steps_i = 5'd7;
      end
      ready_i = 1'b1;
      if (done_o) begin
        fin = 1;
        start_i = 1'b0;
      end
      if (valid_o) begin
        chk({tag, " busy"}, {63'd0, busy_o}, 64'd1);
        if (k + 1 == stall_word && stalls < stall_len) begin
          ready_i = 1'b0;
          stalls++;
          if (use_exp && k < 3) chk({tag, " hold"}, data_o, exp[k]);
        end else begin
          if (use_exp && k < 3) chk($sformatf("%s word%0d", tag, k), data_o, exp[k]);
          chk($sformatf("%s fwd%0d", tag, k), fwd(data_o), prev);
          prev = data_o;
          k++;
        end
      end
    end
    if (!fin) chk({tag, " done_timeout"}, 64'd0, 64'd1);
    chk({tag, " count"}, 64'(k), 64'(steps));
    @(negedge clk);
    chk({tag, " done_single"}, {63'd0, done_o}, 64'd0);
    chk({tag, " idle_busy"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    logic [63:0] rs;
    vecs[0] = mk(C, 5'd3, 0, 0, 0, 64'h0100000000000000, 64'h0200000000000000, 64'h0400000000000000);
    vecs[1] = mk(64'd0, 5'd2, 0, 0, 0, 64'd0, 64'd0, 64'd0);
    vecs[2] = mk(C, 5'd3, 2, 4, 1, 64'h0100000000000000, 64'h0200000000000000, 64'h0400000000000000);
    vecs[3] = mk(64'h0000000000000001, 5'd2, 0, 0, 0, 64'h0000000000000002, 64'h0000000000000004, 64'd0);
    vecs[4] = mk(64'h0000000000000080, 5'd1, 1, 2, 0, 64'h5DB1C1FF32C357B8, 64'd0, 64'd0);

    rst_n = 1'b0; start_i = 1'b0; seed_i = '0; steps_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", {63'd0, busy_o}, 64'd0);
    chk("rst valid", {63'd0, valid_o}, 64'd0);
    chk("rst done", {63'd0, done_o}, 64'd0);
    chk("rst data", data_o, 64'd0);
    chk("rst err", {63'd0, err_o}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_stream(vecs[i].seed, vecs[i].steps, vecs[i].stall_word, vecs[i].stall_len,
                 vecs[i].hold_start, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Zero-step load: done two cycles after start, nothing streamed.
    @(negedge clk);
    start_i = 1'b1; seed_i = C; steps_i = 5'd0; ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("z0 done", {63'd0, done_o}, 64'd0);
    chk("z0 valid", {63'd0, valid_o}, 64'd0);
    chk("z0 busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    chk("z0 done_pulse", {63'd0, done_o}, 64'd1);
    chk("z0 valid2", {63'd0, valid_o}, 64'd0);
    chk("z0 busy2", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    chk("z0 done_end", {63'd0, done_o}, 64'd0);

    // Asynchronous reset after the first handshake.
    @(negedge clk);
    start_i = 1'b1; seed_i = C; steps_i = 5'd3; ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("ar word1", data_o, 64'h0100000000000000);
    @(negedge clk);
    chk("ar word2", data_o, 64'h0200000000000000);
    #2 rst_n = 1'b0;
    #1;
    chk("ar valid", {63'd0, valid_o}, 64'd0);
    chk("ar busy", {63'd0, busy_o}, 64'd0);
    chk("ar data", data_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ar no_done", {63'd0, done_o}, 64'd0);
    end
    run_stream(vecs[0].seed, vecs[0].steps, 0, 0, 0, 1'b1, vecs[0].exp, "fresh");

    rs = {$urandom, $urandom};
    run_stream(rs, 5'd24, 5, 3, 0, 1'b0, '0, "rnd");
    chk("rnd err", {63'd0, err_o}, 64'd0);

`ifdef BASH_F_CONST_REV_CHK_FWD_EN
    begin
      logic [63:0] bad;
      bit got;
      @(negedge clk);
      start_i = 1'b1; seed_i = C; steps_i = 5'd4; ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        if (valid_o) got = 1;
        else @(negedge clk);
      end
      if (!got) chk("inj timeout", 64'd0, 64'd1);
      bad = dut.r_word ^ 64'h1;
      force dut.r_word = bad;
      @(negedge clk);
      release dut.r_word;
      chk("inj err", {63'd0, err_o}, 64'd1);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (done_o) got = 1;
      end
      if (!got) chk("inj done_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
      chk("inj err_sticky", {63'd0, err_o}, 64'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bash_f_const_rev.md
Name: bash_f_const_rev

Overview:
- Inverse (backward-stepping) generator for the bash-f round constant: undoes one forward constant update per step.
- Forward step, with x the little-endian integer of the 64-bit word: c' = (x >> 1) XOR (x[0] ? C : 0).
- Used to regenerate the round-constant sequence in reverse order for the inverse permutation and for decryption-side schedules.
- Accepts a seed constant plus a step count, then streams one recovered constant per step over a valid/ready handshake.

Parameters:
- C_CONST, 64'hAED8E07F99E12BDC, bash-f constant in data (byte-stream) order.
- CNT_W, 5, width of the step counter (max 31 steps; bash-f uses 24).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  load request; accepted only in IDLE.
- seed_i  in  64  final constant to step back from, data order.
- steps_i  in  CNT_W  number of backward steps to produce.
- busy_o  out  1  high in RUN.
- data_o  out  64  recovered constant, data order.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i.
- done_o  out  1  one-cycle pulse after the last word is accepted, or on a zero-step load.
- err_o  out  1  forward-check mismatch, sticky; present only with CHK_FWD_EN, tied 0 otherwise.

Behaviour:
- Reset values: busy_o=0, valid_o=0, done_o=0, data_o=0, err_o=0; state=IDLE; internal state register and counter = 0.
- Inverse step on word y (data order):
  - b = y[7], i.e. bit 63 of the little-endian integer. b is always 1 if the forward step XORed C, because C's LE bit 63 is 1 and x>>1 has bit 63 = 0.
  - t = b ? y ^ C_CONST : y.
  - x_le = {t_le[62:0], b}; result = byte-reversed x_le back to data order.
  - Combinational step, 64-bit, no carries.
- IDLE: on start_i=1 latch seed_i into the state register.
  - steps_i=0: go to FIN, done_o=1 next cycle, no outputs.
  - Otherwise: counter=steps_i, go to RUN.
  - start_i is ignored outside IDLE.
- RUN:
  - Each output word is the inverse step of the current state register.
  - valid_o rises the cycle after the load (1-cycle latency); data_o is registered.
  - On a handshake: the state register takes data_o, the counter decrements, and the next word appears in the following cycle. valid_o stays high, giving back-to-back throughput of 1 word/cycle.
  - While valid_o=1 and ready_i=0: data_o and valid_o hold stable.
  - Handshake when counter==1: valid_o drops next cycle, go to FIN.
- FIN: done_o=1 for exactly one cycle, then IDLE. start_i in FIN is ignored.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous); no done_o is produced.
- The sequence is the exact reverse of the forward generator: applying the forward step to output k yields output k-1 (the seed for k=1).

Optional Feature:
- Macro: BASH_F_CONST_REV_CHK_FWD_EN.
- Defined:
  - Instantiates a forward-step model that compares forward(data_o) against the previous word (seed for the first) on every handshake.
  - Any mismatch sets err_o, sticky until reset; streaming is unaffected.
- Not defined: no checker logic; err_o tied to 0.

Test Plan:
- seed=AED8E07F99E12BDC, steps=3, ready_i=1 -> data_o 0100000000000000, 0200000000000000, 0400000000000000 on consecutive cycles; done_o pulses once after the third handshake.
- seed=0, steps=2 -> two words, both 0000000000000000; done_o pulses once.
- seed=AED8E07F99E12BDC, steps=3, ready_i low for 4 cycles on word 2 -> data_o holds 0200000000000000 with valid_o=1 throughout; sequence otherwise unchanged.
- steps=0 -> no valid_o; done_o pulses 2 cycles after start_i; busy_o stays 0.
- rst_n low after the first handshake -> valid_o, busy_o, data_o read 0 immediately; a new start behaves as a fresh run.
- Random 64-bit seed, steps=24, macro defined -> forward model of the bench matches every word; err_o stays 0. Forcing a corrupted state bit in sim -> err_o=1, sticky.
